// File: rtl/ntt_stage_sequencer.sv
// ntt_stage_sequencer: multi-stage NTT/INTT control sequencer.
// Ports: clk/rst_n; start/abort/inverse in; bn_ma_out_en, r_enable_out, ntt_done
// status in; TF_init_base/TF_init_const/TF_ren/it_depth_cnt to TF_gen,
// AGU_enable, r_enable, w_enable, ntt_enable to datapath; busy/done status out.
module ntt_stage_sequencer #(
    parameter int NUM_STAGE    = 3,
    parameter int BU_PER_STAGE = 4,
    parameter int BUF_CYCLES   = 11,
    parameter int INIT_CYCLES  = 16,
    parameter int D_WIDTH      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               inverse,
    input  logic               bn_ma_out_en,
    input  logic               r_enable_out,
    input  logic               ntt_done,
    output logic               TF_init_base,
    output logic               TF_init_const,
    output logic               TF_ren,
    output logic [D_WIDTH-1:0] it_depth_cnt,
    output logic               AGU_enable,
    output logic               r_enable,
    output logic               w_enable,
    output logic               ntt_enable,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [D_WIDTH-1:0] ONE        = D_WIDTH'(1);
    localparam logic [D_WIDTH-1:0] STAGE_LAST = D_WIDTH'(NUM_STAGE - 1);
    localparam logic [D_WIDTH-1:0] BU_LAST    = D_WIDTH'(BU_PER_STAGE - 1);
    localparam logic [D_WIDTH-1:0] DRAIN_LAST = D_WIDTH'(BUF_CYCLES - 1);
    localparam logic [D_WIDTH-1:0] INIT_LAST  = D_WIDTH'(INIT_CYCLES - 1);

    state_t             state;
    logic [D_WIDTH-1:0] stage;
    logic [D_WIDTH-1:0] bu_cnt;
    logic [D_WIDTH-1:0] init_cnt;
    logic [D_WIDTH-1:0] drain_cnt;
    logic               inv_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            stage     <= '0;
            bu_cnt    <= '0;
            init_cnt  <= '0;
            drain_cnt <= '0;
            inv_r     <= 1'b0;
        end else if (abort) begin
            // Abort overrides every transition, including a same-cycle start.
            state     <= S_IDLE;
            stage     <= '0;
            bu_cnt    <= '0;
            init_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_INIT;
                        stage     <= '0;
                        bu_cnt    <= '0;
                        init_cnt  <= '0;
                        drain_cnt <= '0;
                        inv_r     <= inverse;
                    end
                end
                S_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        init_cnt <= '0;
                        state    <= S_RUN;
                    end else begin
                        init_cnt <= init_cnt + ONE;
                    end
                end
                S_RUN: begin
                    if (bn_ma_out_en) begin
                        if (bu_cnt == BU_LAST) begin
                            bu_cnt    <= '0;
                            drain_cnt <= '0;
                            state     <= S_DRAIN;
                        end else begin
                            bu_cnt <= bu_cnt + ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        drain_cnt <= '0;
                        if (stage == STAGE_LAST) begin
                            state <= S_DONE;
                        end else begin
                            stage <= stage + ONE;
                            state <= S_RUN;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + ONE;
                    end
                end
                S_DONE: begin
                    stage <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode the registered state; only the read path follows
    // bn_ma_out_en combinationally so the AGU address is used in-cycle.
    always_comb begin
        TF_init_base  = 1'b0;
        TF_init_const = 1'b0;
        TF_ren        = 1'b0;
        it_depth_cnt  = '0;
        AGU_enable    = 1'b0;
        r_enable      = 1'b0;
        w_enable      = 1'b0;
        ntt_enable    = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (state)
            S_IDLE: begin
            end
            S_INIT: begin
                TF_init_base  = 1'b1;
                TF_init_const = 1'b1;
                busy          = 1'b1;
            end
            S_RUN: begin
                AGU_enable   = 1'b1;
                r_enable     = bn_ma_out_en;
                TF_ren       = bn_ma_out_en;
                ntt_enable   = r_enable_out;
                w_enable     = ntt_done;
                it_depth_cnt = inv_r ? (STAGE_LAST - stage) : stage;
                busy         = 1'b1;
            end
            S_DRAIN: begin
                ntt_enable   = r_enable_out;
                w_enable     = ntt_done;
                it_depth_cnt = inv_r ? (STAGE_LAST - stage) : stage;
                busy         = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// tb_ntt_stage_sequencer: scoreboard bench for ntt_stage_sequencer.
// Expected it_depth per read and per-run done stats are queued by stimulus.
module tb_ntt_stage_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       inverse = 1'b0;
    logic       en = 1'b0;
    logic       r_enable_out = 1'b0;
    logic       ntt_done = 1'b0;
    logic       TF_init_base, TF_init_const, TF_ren;
    logic [7:0] it_depth_cnt;
    logic       AGU_enable, r_enable, w_enable, ntt_enable, busy, done;

    logic       start_s = 1'b0;
    logic       abort_s = 1'b0;
    logic       inverse_s = 1'b0;
    logic       en_s = 1'b0;
    logic       ib_s, ic_s, tf_s, agu_s, re_s, we_s, ne_s, busy_s, done_s;
    logic [7:0] depth_s;

    always #5 clk = ~clk;

    ntt_stage_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .inverse(inverse), .bn_ma_out_en(en),
        .r_enable_out(r_enable_out), .ntt_done(ntt_done),
        .TF_init_base(TF_init_base), .TF_init_const(TF_init_const),
        .TF_ren(TF_ren), .it_depth_cnt(it_depth_cnt),
        .AGU_enable(AGU_enable), .r_enable(r_enable), .w_enable(w_enable),
        .ntt_enable(ntt_enable), .busy(busy), .done(done)
    );

    ntt_stage_sequencer #(
        .NUM_STAGE(1), .BU_PER_STAGE(1), .BUF_CYCLES(1), .INIT_CYCLES(2)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s),
        .inverse(inverse_s), .bn_ma_out_en(en_s),
        .r_enable_out(r_enable_out), .ntt_done(ntt_done),
        .TF_init_base(ib_s), .TF_init_const(ic_s), .TF_ren(tf_s),
        .it_depth_cnt(depth_s), .AGU_enable(agu_s), .r_enable(re_s),
        .w_enable(we_s), .ntt_enable(ne_s), .busy(busy_s), .done(done_s)
    );

    typedef struct {
        int tf;
        int init;
        int cyc;
    } done_exp_t;

    int        rd_q[$];
    done_exp_t done_q[$];
    int        n_chk = 0;
    int        n_fail = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] outs_big();
        return {20'd0, TF_init_base, TF_init_const, TF_ren, AGU_enable,
                r_enable, w_enable, ntt_enable, busy, done, 3'd0}
               | {24'd0, it_depth_cnt};
    endfunction

    // Monitor: pops expectations on each read and on each done pulse.
    logic prev_busy = 1'b0;
    int   tf_cnt = 0;
    int   init_cnt = 0;
    int   cyc = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                tf_cnt   = 0;
                init_cnt = 0;
                cyc      = 2;
            end else if (busy) begin
                cyc++;
            end
            if (TF_init_base) begin
                init_cnt++;
                check("init_const", TF_init_const, 1);
            end
            if (r_enable) begin
                tf_cnt++;
                check("tf_ren", TF_ren, 1);
                if (rd_q.size() == 0) fail_now("unexpected r_enable");
                else check("it_depth", it_depth_cnt, rd_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    fail_now("unexpected done");
                end else begin
                    done_exp_t e;
                    e = done_q.pop_front();
                    check("tf_total", tf_cnt, e.tf);
                    check("init_cycles", init_cnt, e.init);
                    if (e.cyc >= 0) check("done_cycle", cyc, e.cyc);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input bit inv, input int n_st);
        for (int s = 0; s < n_st; s++)
            for (int b = 0; b < 4; b++)
                rd_q.push_back(inv ? 2 - s : s);
    endtask

    task automatic push_done(input int c);
        done_exp_t e;
        e.tf   = 12;
        e.init = 16;
        e.cyc  = c;
        done_q.push_back(e);
    endtask

    task automatic wait_idle(input bit toggle);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (toggle) en = ~en;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("timeout waiting for idle");
    endtask

    initial begin
        #12;
        check("reset_outputs", outs_big(), 0);
        rst_n = 1'b1;
        tick();
        check("idle_outputs", outs_big(), 0);

        en = 1'b1;
        #1;
        check("idle_ignores_en", r_enable, 0);

        // Forward run, en held high.
        push_run(0, 3);
        push_done(63);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        wait_idle(0);

        // Inverse run.
        inverse = 1'b1;
        push_run(1, 3);
        push_done(63);
        start = 1'b1;
        tick();
        start = 1'b0;
        inverse = 1'b0;
        wait_idle(0);

        // Toggling address-valid.
        push_run(0, 3);
        push_done(-1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(1);
        en = 1'b1;

        // Abort on the second read of stage 1.
        rd_q.push_back(0); rd_q.push_back(0);
        rd_q.push_back(0); rd_q.push_back(0);
        rd_q.push_back(1); rd_q.push_back(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (32) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_agu", AGU_enable, 0);
        repeat (20) tick();
        check("abort_queue_drained", rd_q.size(), 0);

        // Abort with start in IDLE.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start", busy, 0);

        // Restart from stage 0, with ignored starts in RUN and DRAIN.
        push_run(0, 3);
        push_done(63);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (17) tick();
        check("in_run", AGU_enable, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("in_drain", AGU_enable, 0);
        start = 1'b1;
        r_enable_out = 1'b1;
        ntt_done = 1'b0;
        #1;
        check("drain_ntt_en", ntt_enable, 1);
        check("drain_w_en0", w_enable, 0);
        r_enable_out = 1'b0;
        ntt_done = 1'b1;
        #1;
        check("drain_ntt_en0", ntt_enable, 0);
        check("drain_w_en", w_enable, 1);
        ntt_done = 1'b0;
        tick();
        start = 1'b0;
        wait_idle(0);
        r_enable_out = 1'b1;
        #1;
        check("idle_ntt_en", ntt_enable, 0);
        r_enable_out = 1'b0;

        // Async reset during DRAIN.
        push_run(0, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (22) tick();
        r_enable_out = 1'b1;
        ntt_done = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs_big(), 0);
        r_enable_out = 1'b0;
        ntt_done = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("reset_queue_drained", rd_q.size(), 0);
        check("post_reset_idle", busy, 0);

        // Minimal configuration instance.
        en_s = 1'b1;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        check("small_init", ib_s, 1);
        tick();
        tick();
        check("small_read", re_s, 1);
        check("small_tf_ren", tf_s, 1);
        tick();
        check("small_drain_read", re_s, 0);
        check("small_drain_done", done_s, 0);
        tick();
        check("small_done", done_s, 1);
        tick();
        check("small_done_pulse", done_s, 0);
        check("small_idle", busy_s, 0);

        check("rd_q_empty", rd_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
